// File: rtl/ibis_texture_pkg.sv
// Shared texture types and default geometry for the texture sampler and the mapper.
package ibis_texture_pkg;

  localparam int unsigned TILE_SIZE_POW2_DEF  = 7;
  localparam int unsigned TEXEL_WIDTH_DEF     = 16;
  localparam int unsigned FIFO_DEPTH_POW2_DEF = 2;
  localparam int unsigned TILE_ADDR_W_DEF     = 2 * TILE_SIZE_POW2_DEF;

  typedef logic [TEXEL_WIDTH_DEF-1:0] texel_t;
  typedef logic [TILE_ADDR_W_DEF-1:0] tile_addr_t;

  typedef struct packed {
    texel_t data;
    logic   transparent;
  } sample_t;

endpackage

// File: rtl/ibis_tile_ram.sv
// Simple dual-port tile RAM: one write port, one registered read port, read-first.
module ibis_tile_ram
  import ibis_texture_pkg::*;
#(
  parameter int unsigned ADDR_W = TILE_ADDR_W_DEF,
  parameter int unsigned DATA_W = TEXEL_WIDTH_DEF
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Non-blocking write and read in one block gives old data on a same-address collision.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ibis_texture_sampler.sv
// Texture sampler: reads one texel per accepted map request, substitutes border colour
// on stencil failure, and buffers samples in a credit-managed output FIFO.
module ibis_texture_sampler
  import ibis_texture_pkg::*;
#(
  parameter int unsigned TILE_SIZE_POW2  = TILE_SIZE_POW2_DEF,
  parameter int unsigned TEXEL_WIDTH     = TEXEL_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH_POW2 = FIFO_DEPTH_POW2_DEF
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        enable,
  input  logic                        map_valid,
  input  logic [2*TILE_SIZE_POW2-1:0] map_address,
  input  logic                        stencil_test,
  output logic                        map_stall,
  input  logic [TEXEL_WIDTH-1:0]      border_color,
  input  logic                        tile_we,
  input  logic [2*TILE_SIZE_POW2-1:0] tile_waddr,
  input  logic [TEXEL_WIDTH-1:0]      tile_wdata,
  output logic                        texel_valid,
  input  logic                        texel_ready,
  output logic [TEXEL_WIDTH-1:0]      texel_data,
  output logic                        texel_transparent
);

  localparam int unsigned ADDR_W     = 2 * TILE_SIZE_POW2;
  localparam int unsigned FIFO_DEPTH = 1 << FIFO_DEPTH_POW2;
  localparam int unsigned PTR_W      = FIFO_DEPTH_POW2;
  localparam int unsigned CNT_W      = FIFO_DEPTH_POW2 + 1;

  logic                   accept_c;
  logic                   push_c;
  logic                   pop_c;
  logic [CNT_W-1:0]       credits_c;
  logic [TEXEL_WIDTH-1:0] ram_rdata;
  logic [TEXEL_WIDTH-1:0] push_data_c;

  logic                   s1_valid_q;
  logic                   s1_stencil_q;
  logic [TEXEL_WIDTH-1:0] s1_border_q;

  logic [TEXEL_WIDTH-1:0] fifo_data_q   [FIFO_DEPTH];
  logic                   fifo_transp_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;

  ibis_tile_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (TEXEL_WIDTH)
  ) u_tile_ram (
    .clk_i   (aclk),
    .we_i    (tile_we),
    .waddr_i (tile_waddr),
    .wdata_i (tile_wdata),
    .re_i    (accept_c),
    .raddr_i (map_address),
    .rdata_o (ram_rdata)
  );

  // Stage 1 is counted as a reserved FIFO slot, so a push can never hit a full FIFO.
  assign credits_c   = count_q + CNT_W'(s1_valid_q);
  assign map_stall   = (credits_c == CNT_W'(FIFO_DEPTH));
  assign accept_c    = enable & map_valid & ~map_stall;
  assign push_c      = s1_valid_q;
  assign pop_c       = texel_valid & texel_ready;
  assign push_data_c = s1_stencil_q ? ram_rdata : s1_border_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid_q   <= 1'b0;
      s1_stencil_q <= 1'b0;
      s1_border_q  <= '0;
    end else begin
      s1_valid_q <= accept_c;
      if (accept_c) begin
        s1_stencil_q <= stencil_test;
        s1_border_q  <= border_color;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge aclk) begin
    if (push_c) begin
      fifo_data_q[wr_ptr_q]   <= push_data_c;
      fifo_transp_q[wr_ptr_q] <= ~s1_stencil_q;
    end
  end

  assign texel_valid       = (count_q != '0);
  assign texel_data        = texel_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign texel_transparent = texel_valid & fifo_transp_q[rd_ptr_q];

endmodule

// File: tb/tb_ibis_texture_sampler.sv
// Self-checking bench for ibis_texture_sampler: vector table plus scoreboarded sequences.
module tb_ibis_texture_sampler;
  import ibis_texture_pkg::*;

  logic        aclk;
  logic        aresetn;
  logic        enable;
  logic        map_valid;
  logic [13:0] map_address;
  logic        stencil_test;
  logic        map_stall;
  logic [15:0] border_color;
  logic        tile_we;
  logic [13:0] tile_waddr;
  logic [15:0] tile_wdata;
  logic        texel_valid;
  logic        texel_ready;
  logic [15:0] texel_data;
  logic        texel_transparent;

  ibis_texture_sampler dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .enable            (enable),
    .map_valid         (map_valid),
    .map_address       (map_address),
    .stencil_test      (stencil_test),
    .map_stall         (map_stall),
    .border_color      (border_color),
    .tile_we           (tile_we),
    .tile_waddr        (tile_waddr),
    .tile_wdata        (tile_wdata),
    .texel_valid       (texel_valid),
    .texel_ready       (texel_ready),
    .texel_data        (texel_data),
    .texel_transparent (texel_transparent)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic        do_wr;
    logic [13:0] waddr;
    logic [15:0] wdata;
    logic [13:0] raddr;
    logic        stencil;
    logic [15:0] border;
    logic [15:0] exp_data;
    logic        exp_transp;
  } vec_t;

  vec_t    vecs [6];
  sample_t exp_q [$];
  int      checks = 0;
  int      errors = 0;
  int      outs   = 0;
  int      outs_before;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_req(input logic [13:0] addr, input logic st, input logic [15:0] bc);
    map_valid    = 1'b1;
    map_address  = addr;
    stencil_test = st;
    border_color = bc;
  endtask

  // Scoreboard: every handshake at the head is compared with the oldest expected sample.
  always @(negedge aclk) begin : monitor
    sample_t e;
    if (aresetn && texel_valid && texel_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h/%0b expected nothing", texel_data, texel_transparent);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(texel_data), 32'(e.data));
        chk("out_transparent", 32'(texel_transparent), 32'(e.transparent));
      end
      outs++;
    end
  end

  initial begin
    vecs[0] = '{1'b1, 14'h0102, 16'hABCD, 14'h0102, 1'b1, 16'h0000, 16'hABCD, 1'b0};
    vecs[1] = '{1'b0, 14'h0000, 16'h0000, 14'h0102, 1'b0, 16'h0F0F, 16'h0F0F, 1'b1};
    vecs[2] = '{1'b1, 14'h3FFF, 16'hBEEF, 14'h3FFF, 1'b1, 16'h1234, 16'hBEEF, 1'b0};
    vecs[3] = '{1'b1, 14'h0000, 16'h2222, 14'h0000, 1'b1, 16'hFFFF, 16'h2222, 1'b0};
    vecs[4] = '{1'b1, 14'h2A55, 16'h1357, 14'h2A55, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1};
    vecs[5] = '{1'b1, 14'h1234, 16'h0000, 14'h1234, 1'b1, 16'hFFFF, 16'h0000, 1'b0};

    aresetn = 1'b0; enable = 1'b0; map_valid = 1'b0; map_address = '0;
    stencil_test = 1'b0; border_color = '0; tile_we = 1'b0; tile_waddr = '0;
    tile_wdata = '0; texel_ready = 1'b0;
    repeat (3) @(posedge aclk);
    #3 aresetn = 1'b1;
    cyc();
    chk("reset_valid", 32'(texel_valid), 32'd0);
    chk("reset_data", 32'(texel_data), 32'd0);
    chk("reset_transparent", 32'(texel_transparent), 32'd0);
    chk("reset_stall", 32'(map_stall), 32'd0);

    // Vector table: single request, latency and head contents, then one pop
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].do_wr) begin
        tile_we = 1'b1; tile_waddr = vecs[i].waddr; tile_wdata = vecs[i].wdata;
        cyc();
        tile_we = 1'b0;
      end
      drive_req(vecs[i].raddr, vecs[i].stencil, vecs[i].border);
      exp_q.push_back('{data: vecs[i].exp_data, transparent: vecs[i].exp_transp});
      cyc();
      map_valid = 1'b0;
      chk("lat_e0_valid", 32'(texel_valid), 32'd0);
      cyc();
      chk("lat_e1_valid", 32'(texel_valid), 32'd1);
      chk("vec_data", 32'(texel_data), 32'(vecs[i].exp_data));
      chk("vec_transparent", 32'(texel_transparent), 32'(vecs[i].exp_transp));
      texel_ready = 1'b1;
      cyc();
      texel_ready = 1'b0;
      chk("vec_drained", 32'(texel_valid), 32'd0);
    end

    // enable low: requests ignored
    enable = 1'b0;
    drive_req(14'h0102, 1'b0, 16'h7777);
    repeat (3) cyc();
    map_valid = 1'b0;
    cyc();
    chk("disabled_no_output", 32'(texel_valid), 32'd0);
    enable = 1'b1;

    // Backpressure: 4 accepts fill the credits, a 5th is dropped until one pop
    for (int k = 0; k < 4; k++) begin
      chk("stall_pre", 32'(map_stall), 32'd0);
      drive_req(14'h0000, 1'b0, 16'h1000 + 16'(k));
      exp_q.push_back('{data: 16'h1000 + 16'(k), transparent: 1'b1});
      cyc();
    end
    chk("stall_after4", 32'(map_stall), 32'd1);
    border_color = 16'hDEAD;
    cyc();
    chk("stall_hold1", 32'(map_stall), 32'd1);
    cyc();
    chk("stall_hold2", 32'(map_stall), 32'd1);
    drive_req(14'h0102, 1'b1, 16'h0000);
    exp_q.push_back('{data: 16'hABCD, transparent: 1'b0});
    texel_ready = 1'b1;
    cyc();
    texel_ready = 1'b0;
    chk("stall_release", 32'(map_stall), 32'd0);
    cyc();
    map_valid = 1'b0;
    chk("stall_reassert", 32'(map_stall), 32'd1);
    texel_ready = 1'b1;
    repeat (8) cyc();
    chk("stall_drained", 32'(exp_q.size()), 32'd0);

    // Read-first collision, then read of the new value
    tile_we = 1'b1; tile_waddr = 14'h0000; tile_wdata = 16'h1111;
    drive_req(14'h0000, 1'b1, 16'h0000);
    exp_q.push_back('{data: 16'h2222, transparent: 1'b0});
    cyc();
    tile_we = 1'b0; map_valid = 1'b0;
    repeat (3) cyc();
    drive_req(14'h0000, 1'b1, 16'h0000);
    exp_q.push_back('{data: 16'h1111, transparent: 1'b0});
    cyc();
    map_valid = 1'b0;
    repeat (4) cyc();
    chk("rfirst_drained", 32'(exp_q.size()), 32'd0);

    // Back-to-back requests at full rate
    for (int i = 0; i < 8; i++) begin
      tile_we = 1'b1; tile_waddr = 14'h0040 + 14'(i * 37); tile_wdata = 16'hC000 + 16'(i);
      cyc();
    end
    tile_we = 1'b0;
    outs_before = outs;
    for (int i = 0; i < 8; i++) begin
      chk("b2b_stall", 32'(map_stall), 32'd0);
      drive_req(14'h0040 + 14'(i * 37), 1'b1, 16'h0000);
      exp_q.push_back('{data: 16'hC000 + 16'(i), transparent: 1'b0});
      cyc();
    end
    map_valid = 1'b0;
    repeat (4) cyc();
    chk("b2b_count", 32'(outs - outs_before), 32'd8);
    chk("b2b_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset with 3 buffered samples and one in stage 1
    texel_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_req(14'h0000, 1'b0, 16'h5000 + 16'(k));
      cyc();
    end
    map_valid = 1'b0;
    chk("prereset_stall", 32'(map_stall), 32'd1);
    #2 aresetn = 1'b0;
    #1;
    chk("async_reset_valid", 32'(texel_valid), 32'd0);
    chk("async_reset_data", 32'(texel_data), 32'd0);
    chk("async_reset_transparent", 32'(texel_transparent), 32'd0);
    chk("async_reset_stall", 32'(map_stall), 32'd0);
    #2 aresetn = 1'b1;
    texel_ready = 1'b1;
    repeat (5) begin
      cyc();
      chk("post_reset_idle", 32'(texel_valid), 32'd0);
    end
    drive_req(14'h0102, 1'b1, 16'h0000);
    exp_q.push_back('{data: 16'hABCD, transparent: 1'b0});
    cyc();
    map_valid = 1'b0;
    cyc();
    chk("post_reset_valid", 32'(texel_valid), 32'd1);
    repeat (3) cyc();
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
